dot_scan_controller: RTL and testbench
======================================

DOT_SCAN_CONTROLLER -- requirements
Module: dot_scan_controller

Interface
REQ-001 Parameter: MEM_ADDRESS_LENGTH, default 7, width of row/column indices.
REQ-002 Parameter: DWELL_WIDTH, default 16, width of the dwell counter and dwell_cycles.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level-sampled scan request; acted on only in IDLE.
REQ-006 stop  in  1  abort request; sticky until taken.
REQ-007 continuous  in  1  1 = restart the frame after completion; 0 = single frame.
REQ-008 last_row  in  MEM_ADDRESS_LENGTH  index of the final row scanned.
REQ-009 last_col  in  MEM_ADDRESS_LENGTH  index of the final column scanned.
REQ-010 dwell_cycles  in  DWELL_WIDTH  motor-on cycles per dot; 0 is treated as 1.
REQ-011 firing_bit  in  1  dot-enable from the dot table at the current row/col (combinational).
REQ-012 firing_data  in  1  dot-pattern bit from the dot table at the current row/col (combinational).
REQ-013 row_select  out  MEM_ADDRESS_LENGTH  registered row index driven to the dot table.
REQ-014 col_select  out  MEM_ADDRESS_LENGTH  registered column index driven to the dot table.
REQ-015 motor_out  out  1  registered actuator drive.
REQ-016 advance  out  1  one-cycle pulse per dot stepped.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 host_write_ok  out  1  equals ~busy; the host writes the tables only while this is high.
REQ-019 frame_done  out  1  one-cycle pulse on completion of a full frame.
REQ-020 frame_count  out  16  completed frames, modulo 2^16.

Function
REQ-021 FSM states: IDLE, SETTLE, FIRE, STEP.
REQ-022 IDLE with start=1 and no pending stop: latch last_row, last_col and dwell_cycles, set row/col to 0, go to SETTLE; busy rises the next cycle.
REQ-023 SETTLE lasts exactly 1 cycle (table lookup settles); it samples firing_bit & firing_data into fire_q, loads the dwell counter, then goes to FIRE.
REQ-024 FIRE: motor_out = fire_q for exactly max(dwell,1) cycles, then go to STEP.
REQ-025 STEP lasts 1 cycle: motor_out=0, advance=1, indices update, then go to SETTLE or IDLE.
REQ-026 Dot period is max(dwell,1)+2 cycles; a frame is (last_row+1)*(last_col+1) dots, row-major, column fastest.
REQ-027 Index update in STEP:
  - col<last_col: col+1.
  - otherwise col=0, and row+1 if row<last_row.
REQ-028 Final dot (row=last_row, col=last_col) in STEP:
  - frame_done=1; frame_count increments, wrapping 0xFFFF->0.
  - continuous=1 and no pending stop: row=col=0, return to SETTLE.
  - otherwise go to IDLE.
REQ-029 stop latches into stop_pend in any state. It takes effect only at the STEP that ends the current dot: go to IDLE without frame_done unless that dot is the final dot. stop_pend clears on entering IDLE.
REQ-030 start while busy is ignored; start and stop asserted together in IDLE: stop wins, remains IDLE, stop_pend clears.
REQ-031 Latched limits are fixed for the frame; input changes take effect only at the next start or continuous restart.
REQ-032 motor_out is never high outside FIRE; advance and frame_done are never high outside STEP.

Reset
REQ-033 reset_n low asynchronously forces: state=IDLE, row/col/frame_count=0, all outputs 0 except host_write_ok=1, stop_pend=0.
REQ-034 Reset mid-FIRE drops motor_out in the same cycle, without waiting for the clock; no frame_done is produced.

Structure
REQ-035 Shared package: FSM state encoding, DWELL_WIDTH default, frame_count width constant.
REQ-036 One sub-module, scan_index_counter: row/col counter with clear, step, limits and a last-dot flag.

Verification
REQ-037 last_row=1, last_col=2, dwell=3, all dots firing: 6 advance pulses, each 5 cycles apart; motor_out high 3 cycles per dot; one frame_done; frame_count=1; busy drops after the last STEP.
REQ-038 dwell=0: motor_out high exactly 1 cycle per dot; dot period is 3 cycles.
REQ-039 Pattern with firing_bit=1 and firing_data=0 at (0,1): motor_out stays 0 for that dot, and advance still pulses.
REQ-040 continuous=1, 1x1 frame, dwell=2: frame_done every 4 cycles; stop asserted mid-FIRE yields one more frame_done, then IDLE.
REQ-041 stop at dot (0,0) of a 2x2 frame: IDLE after that dot's STEP, frame_done never pulses, frame_count unchanged.
REQ-042 reset_n low during FIRE: motor_out drops in the same cycle; all state returns to reset values; frame_count=0.

Source files
------------

// File: rtl/dot_scan_controller_pkg.sv
// ----------------------------------------------------------------------------
// dot_scan_controller_pkg
// Shared definitions for the dot scan controller:
//   - scan_state_e      : FSM state encoding (IDLE, SETTLE, FIRE, STEP)
//   - DSC_DWELL_WIDTH_DEFAULT : default width of the dwell counter
//   - DSC_FRAME_COUNT_W : width of the completed-frame counter
//   - state_is_busy()   : true for every state except IDLE
// ----------------------------------------------------------------------------
package dot_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FIRE   = 2'd2,
        ST_STEP   = 2'd3
    } scan_state_e;

    localparam int DSC_DWELL_WIDTH_DEFAULT = 16;
    localparam int DSC_FRAME_COUNT_W       = 16;

    function automatic logic state_is_busy(input scan_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/dot_scan_controller_scan_index_counter.sv
// ----------------------------------------------------------------------------
// scan_index_counter
// Row-major row/column index counter for the dot table (column fastest).
// Ports:
//   clock, reset_n         : clock, asynchronous active-low reset
//   i_clear                : force row = col = 0 (wins over i_step)
//   i_step                 : advance one dot; col wraps to 0 after i_last_col,
//                            row increments on wrap until it reaches i_last_row
//   i_last_row, i_last_col : inclusive limits of the frame
//   o_row, o_col           : registered indices
//   o_last_dot             : current indices are the final dot of the frame
// ----------------------------------------------------------------------------
module scan_index_counter #(
    parameter int AW = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_clear,
    input  logic          i_step,
    input  logic [AW-1:0] i_last_row,
    input  logic [AW-1:0] i_last_col,
    output logic [AW-1:0] o_row,
    output logic [AW-1:0] o_col,
    output logic          o_last_dot
);

    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] r_row;
    logic [AW-1:0] r_col;

    // Row/column index registers with clear and row-major stepping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= IDX_ZERO;
            r_col <= IDX_ZERO;
        end else if (i_clear) begin
            r_row <= IDX_ZERO;
            r_col <= IDX_ZERO;
        end else if (i_step) begin
            if (r_col < i_last_col) begin
                r_col <= r_col + IDX_ONE;
            end else begin
                r_col <= IDX_ZERO;
                if (r_row < i_last_row) begin
                    r_row <= r_row + IDX_ONE;
                end
            end
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_last_dot = (r_row == i_last_row) && (r_col == i_last_col);

endmodule

// File: rtl/dot_scan_controller.sv
// ----------------------------------------------------------------------------
// dot_scan_controller
// Walks a dot table row-major and drives an actuator for each enabled dot.
// Each dot takes SETTLE (1 cycle, table lookup) + FIRE (max(dwell,1) cycles)
// + STEP (1 cycle, advance pulse) = max(dwell,1)+2 cycles.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   start                    : scan request, honoured only in IDLE
//   stop                     : abort request, held pending until the next STEP
//   continuous               : restart the frame after its final dot
//   last_row, last_col       : inclusive frame limits (latched at start)
//   dwell_cycles             : motor-on cycles per dot, 0 behaves as 1
//   firing_bit, firing_data  : combinational dot-table outputs at row/col
//   row_select, col_select   : registered dot-table address
//   motor_out                : registered actuator drive (FIRE only)
//   advance                  : one-cycle pulse per dot (STEP)
//   busy, host_write_ok      : busy outside IDLE; host_write_ok = ~busy
//   frame_done               : one-cycle pulse on the STEP of the final dot
//   frame_count              : completed frames, wraps at 2^16
// ----------------------------------------------------------------------------
module dot_scan_controller
    import dot_scan_controller_pkg::*;
#(
    parameter int MEM_ADDRESS_LENGTH = 7,
    parameter int DWELL_WIDTH        = DSC_DWELL_WIDTH_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          continuous,
    input  logic [MEM_ADDRESS_LENGTH-1:0] last_row,
    input  logic [MEM_ADDRESS_LENGTH-1:0] last_col,
    input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
    input  logic                          firing_bit,
    input  logic                          firing_data,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          motor_out,
    output logic                          advance,
    output logic                          busy,
    output logic                          host_write_ok,
    output logic                          frame_done,
    output logic [DSC_FRAME_COUNT_W-1:0]  frame_count
);

    localparam logic [DWELL_WIDTH-1:0] DWELL_ZERO = {DWELL_WIDTH{1'b0}};
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MEM_ADDRESS_LENGTH-1:0] IDX_ZERO = {MEM_ADDRESS_LENGTH{1'b0}};
    localparam logic [DSC_FRAME_COUNT_W-1:0]  FC_ZERO  = {DSC_FRAME_COUNT_W{1'b0}};
    localparam logic [DSC_FRAME_COUNT_W-1:0]  FC_ONE   = {{(DSC_FRAME_COUNT_W-1){1'b0}}, 1'b1};

    scan_state_e r_state;
    scan_state_e w_next_state;

    logic [MEM_ADDRESS_LENGTH-1:0] r_last_row;
    logic [MEM_ADDRESS_LENGTH-1:0] r_last_col;
    logic [DWELL_WIDTH-1:0]        r_dwell;
    logic [DWELL_WIDTH-1:0]        r_dwell_cnt;
    logic                          r_fire_q;
    logic                          r_stop_pend;

    logic                          r_motor;
    logic                          r_advance;
    logic                          r_busy;
    logic                          r_host_write_ok;
    logic                          r_frame_done;
    logic [DSC_FRAME_COUNT_W-1:0]  r_frame_count;

    logic                          w_latch;
    logic                          w_idx_clear;
    logic                          w_idx_step;
    logic                          w_last_dot;
    logic                          w_stop_eff;
    logic                          w_enter_step;
    logic                          w_motor_next;
    logic [DWELL_WIDTH-1:0]        w_dwell_eff;
    logic [MEM_ADDRESS_LENGTH-1:0] w_row;
    logic [MEM_ADDRESS_LENGTH-1:0] w_col;

    // A stop raised in the very cycle of STEP still ends the scan there.
    assign w_stop_eff   = r_stop_pend | stop;
    assign w_dwell_eff  = (r_dwell == DWELL_ZERO) ? DWELL_ONE : r_dwell;
    assign w_enter_step = (w_next_state == ST_STEP);

    scan_index_counter #(
        .AW (MEM_ADDRESS_LENGTH)
    ) u_index (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (w_idx_clear),
        .i_step     (w_idx_step),
        .i_last_row (r_last_row),
        .i_last_col (r_last_col),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_last_dot (w_last_dot)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus limit-latch and index-counter controls.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_idx_clear  = 1'b0;
        w_idx_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // stop beats start when both arrive together
                if (start && !stop) begin
                    w_next_state = ST_SETTLE;
                    w_latch      = 1'b1;
                    w_idx_clear  = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                w_next_state = ST_FIRE;
            end
            ST_FIRE: begin
                if (r_dwell_cnt <= DWELL_ONE) begin
                    w_next_state = ST_STEP;
                end else begin
                    w_next_state = ST_FIRE;
                end
            end
            ST_STEP: begin
                if (w_last_dot) begin
                    if (continuous && !w_stop_eff) begin
                        // continuous restart re-samples the limits
                        w_next_state = ST_SETTLE;
                        w_latch      = 1'b1;
                        w_idx_clear  = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_idx_step   = 1'b1;
                    end
                end else begin
                    w_idx_step = 1'b1;
                    if (w_stop_eff) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_SETTLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Motor drive for the next cycle: sample the table on leaving SETTLE,
    // hold it through FIRE, force low everywhere else.
    always_comb begin
        w_motor_next = 1'b0;
        if (w_next_state == ST_FIRE) begin
            if (r_state == ST_SETTLE) begin
                w_motor_next = firing_bit & firing_data;
            end else begin
                w_motor_next = r_fire_q;
            end
        end else begin
            w_motor_next = 1'b0;
        end
    end

    // Frame limits, fixed for the whole frame once latched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_row <= IDX_ZERO;
            r_last_col <= IDX_ZERO;
            r_dwell    <= DWELL_ZERO;
        end else if (w_latch) begin
            r_last_row <= last_row;
            r_last_col <= last_col;
            r_dwell    <= dwell_cycles;
        end
    end

    // Per-dot dwell counter and sampled fire decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell_cnt <= DWELL_ZERO;
            r_fire_q    <= 1'b0;
        end else if (r_state == ST_SETTLE) begin
            r_dwell_cnt <= w_dwell_eff;
            r_fire_q    <= firing_bit & firing_data;
        end else if (r_state == ST_FIRE) begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_ONE;
        end
    end

    // Sticky stop request, dropped whenever the FSM lands in IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_pend <= 1'b0;
        end else if (w_next_state == ST_IDLE) begin
            r_stop_pend <= 1'b0;
        end else begin
            r_stop_pend <= r_stop_pend | stop;
        end
    end

    // Registered outputs, computed from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_motor         <= 1'b0;
            r_advance       <= 1'b0;
            r_frame_done    <= 1'b0;
            r_busy          <= 1'b0;
            r_host_write_ok <= 1'b1;
            r_frame_count   <= FC_ZERO;
        end else begin
            r_motor         <= w_motor_next;
            r_advance       <= w_enter_step;
            r_frame_done    <= w_enter_step & w_last_dot;
            r_busy          <= state_is_busy(w_next_state);
            r_host_write_ok <= !state_is_busy(w_next_state);
            if (w_enter_step && w_last_dot) begin
                r_frame_count <= r_frame_count + FC_ONE;
            end
        end
    end

    assign row_select    = w_row;
    assign col_select    = w_col;
    assign motor_out     = r_motor;
    assign advance       = r_advance;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;
    assign host_write_ok = r_host_write_ok;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_dot_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_dot_scan_controller
// Self-checking bench: a dot-index/offset model predicts every output each
// cycle, and directed scans check pulse counts and spacing against literals.
// ----------------------------------------------------------------------------
module tb_dot_scan_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [6:0]  last_row = 7'd0;
    logic [6:0]  last_col = 7'd0;
    logic [15:0] dwell_cycles = 16'd0;
    logic        firing_bit;
    logic        firing_data;
    logic [6:0]  row_select;
    logic [6:0]  col_select;
    logic        motor_out;
    logic        advance;
    logic        busy;
    logic        host_write_ok;
    logic        frame_done;
    logic [15:0] frame_count;

    logic tbl_bit  [0:3][0:3];
    logic tbl_data [0:3][0:3];

    int n_checks = 0;
    int n_err = 0;

    // model state: dot index and offset within the dot (0 settle, 1..D fire, D+1 step)
    int m_active = 0;
    int m_off = 0;
    int m_dot = 0;
    int m_R = 0;
    int m_C = 0;
    int m_D = 1;
    int m_stop = 0;
    int m_count = 0;
    int m_idle_row = 0;
    int m_idle_col = 0;

    dot_scan_controller #(
        .MEM_ADDRESS_LENGTH (7),
        .DWELL_WIDTH        (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .last_row      (last_row),
        .last_col      (last_col),
        .dwell_cycles  (dwell_cycles),
        .firing_bit    (firing_bit),
        .firing_data   (firing_data),
        .row_select    (row_select),
        .col_select    (col_select),
        .motor_out     (motor_out),
        .advance       (advance),
        .busy          (busy),
        .host_write_ok (host_write_ok),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    always #5 clock = ~clock;

    assign firing_bit  = (row_select < 7'd4 && col_select < 7'd4) ?
                         tbl_bit[row_select[1:0]][col_select[1:0]] : 1'b0;
    assign firing_data = (row_select < 7'd4 && col_select < 7'd4) ?
                         tbl_data[row_select[1:0]][col_select[1:0]] : 1'b0;

    function automatic bit tbl_fire(input int r, input int c);
        if (r >= 0 && r < 4 && c >= 0 && c < 4) return tbl_bit[r][c] & tbl_data[r][c];
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_latch();
        m_R = int'(last_row);
        m_C = int'(last_col);
        m_D = (dwell_cycles == 16'd0) ? 1 : int'(dwell_cycles);
    endtask

    task automatic model_step();
        int n;
        int se;
        if (!reset_n) begin
            m_active = 0; m_off = 0; m_dot = 0; m_stop = 0;
            m_count = 0; m_idle_row = 0; m_idle_col = 0;
            return;
        end
        n = (m_R + 1) * (m_C + 1);
        if (m_active == 0) begin
            if (start && !stop) begin
                model_latch();
                m_active = 1; m_dot = 0; m_off = 0;
            end
            m_stop = 0;
        end else begin
            se = (m_stop != 0 || stop) ? 1 : 0;
            if (m_off <= m_D) begin
                m_off++;
                m_stop = se;
                if (m_off == m_D + 1 && m_dot == n - 1) m_count = (m_count + 1) % 65536;
            end else if (m_dot == n - 1) begin
                if (continuous && se == 0) begin
                    model_latch();
                    m_dot = 0; m_off = 0; m_stop = 0;
                end else begin
                    m_active = 0; m_stop = 0;
                    m_idle_row = m_R; m_idle_col = 0;
                end
            end else if (se != 0) begin
                m_active = 0; m_stop = 0;
                m_idle_row = (m_dot + 1) / (m_C + 1);
                m_idle_col = (m_dot + 1) % (m_C + 1);
            end else begin
                m_dot++;
                m_off = 0;
            end
        end
    endtask

    // model advances on the same events as the DUT registers
    initial forever begin
        @(posedge clock or negedge reset_n);
        model_step();
    end

    // per-cycle compare against the model
    initial forever begin
        int er, ec, e_mot, e_adv, e_fd;
        @(negedge clock);
        if (m_active != 0) begin
            er = m_dot / (m_C + 1);
            ec = m_dot % (m_C + 1);
        end else begin
            er = m_idle_row;
            ec = m_idle_col;
        end
        e_mot = (m_active != 0 && m_off >= 1 && m_off <= m_D && tbl_fire(er, ec)) ? 1 : 0;
        e_adv = (m_active != 0 && m_off == m_D + 1) ? 1 : 0;
        e_fd  = (e_adv != 0 && m_dot == (m_R + 1) * (m_C + 1) - 1) ? 1 : 0;
        chk("busy", 32'(busy), 32'(m_active != 0));
        chk("host_write_ok", 32'(host_write_ok), 32'(m_active == 0));
        chk("motor_out", 32'(motor_out), 32'(e_mot));
        chk("advance", 32'(advance), 32'(e_adv));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("row_select", 32'(row_select), 32'(er));
        chk("col_select", 32'(col_select), 32'(ec));
        if (e_adv == 0) chk("frame_count", 32'(frame_count), 32'(m_count));
    end

    task automatic set_table(input logic v);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tbl_bit[r][c]  = v;
                tbl_data[r][c] = v;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #2 start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
    endtask

    // Observe one scan from its first SETTLE until busy falls.
    task automatic run_scan(input int stop_at, input int exp_gap, input int max_cyc,
                            output int n_adv, output int n_mot, output int n_fd,
                            output int n_badgap);
        int last_adv;
        bit done;
        n_adv = 0; n_mot = 0; n_fd = 0; n_badgap = 0;
        last_adv = -1; done = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(negedge clock);
            stop = (cyc == stop_at) ? 1'b1 : 1'b0;
            if (advance) begin
                n_adv++;
                if (last_adv >= 0 && cyc - last_adv != exp_gap) n_badgap++;
                last_adv = cyc;
            end
            if (motor_out) n_mot++;
            if (frame_done) n_fd++;
            if (!busy) done = 1'b1;
        end
        stop = 1'b0;
        chk("scan_terminates", 32'(done), 32'd1);
    endtask

    initial begin
        int a, m, f, g;
        bit seen;
        set_table(1'b1);

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hwo", 32'(host_write_ok), 32'd1);
        chk("rst_motor", 32'(motor_out), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;

        // 2x3 frame, dwell 3; limits changed mid-frame must be ignored
        last_row = 7'd1; last_col = 7'd2; dwell_cycles = 16'd3;
        pulse_start();
        last_col = 7'd0; dwell_cycles = 16'd7;
        run_scan(-1, 5, 100, a, m, f, g);
        chk("t1_advance", 32'(a), 32'd6);
        chk("t1_motor", 32'(m), 32'd18);
        chk("t1_frame_done", 32'(f), 32'd1);
        chk("t1_gap", 32'(g), 32'd0);
        chk("t1_count", 32'(frame_count), 32'd1);

        // dwell 0 behaves as 1: period 3
        last_row = 7'd0; last_col = 7'd1; dwell_cycles = 16'd0;
        pulse_start();
        run_scan(-1, 3, 50, a, m, f, g);
        chk("t2_advance", 32'(a), 32'd2);
        chk("t2_motor", 32'(m), 32'd2);
        chk("t2_gap", 32'(g), 32'd0);
        chk("t2_count", 32'(frame_count), 32'd2);

        // enabled but data 0 at (0,1): no motor, still advances
        tbl_data[0][1] = 1'b0;
        last_row = 7'd0; last_col = 7'd2; dwell_cycles = 16'd2;
        pulse_start();
        run_scan(-1, 4, 50, a, m, f, g);
        chk("t3_advance", 32'(a), 32'd3);
        chk("t3_motor", 32'(m), 32'd4);
        chk("t3_gap", 32'(g), 32'd0);
        tbl_data[0][1] = 1'b1;

        // continuous 1x1 dwell 2, stop in third frame's FIRE
        continuous = 1'b1;
        last_row = 7'd0; last_col = 7'd0; dwell_cycles = 16'd2;
        pulse_start();
        run_scan(9, 4, 60, a, m, f, g);
        continuous = 1'b0;
        chk("t4_frame_done", 32'(f), 32'd3);
        chk("t4_gap", 32'(g), 32'd0);
        chk("t4_motor", 32'(m), 32'd6);
        chk("t4_count", 32'(frame_count), 32'd6);

        // stop during dot (0,0) of a 2x2 frame
        last_row = 7'd1; last_col = 7'd1; dwell_cycles = 16'd1;
        pulse_start();
        run_scan(0, 3, 50, a, m, f, g);
        chk("t5_advance", 32'(a), 32'd1);
        chk("t5_frame_done", 32'(f), 32'd0);
        chk("t5_count", 32'(frame_count), 32'd6);

        // start with stop in IDLE: stays IDLE; next start runs normally
        @(posedge clock); #2 start = 1'b1; stop = 1'b1;
        @(posedge clock); #2 start = 1'b0; stop = 1'b0;
        @(negedge clock);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        last_row = 7'd0; last_col = 7'd0; dwell_cycles = 16'd1;
        pulse_start();
        run_scan(-1, 3, 20, a, m, f, g);
        chk("t6_frame_done", 32'(f), 32'd1);
        chk("t6_count", 32'(frame_count), 32'd7);

        // reset in FIRE drops motor without a clock edge
        last_row = 7'd0; last_col = 7'd1; dwell_cycles = 16'd5;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (motor_out) seen = 1'b1;
        end
        chk("t7_motor_reached", 32'(seen), 32'd1);
        @(posedge clock); #2 reset_n = 1'b0;
        #1;
        chk("t7_async_motor", 32'(motor_out), 32'd0);
        chk("t7_async_busy", 32'(busy), 32'd0);
        chk("t7_async_hwo", 32'(host_write_ok), 32'd1);
        chk("t7_async_count", 32'(frame_count), 32'd0);
        chk("t7_async_row", 32'(row_select), 32'd0);
        chk("t7_async_col", 32'(col_select), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("t7_post_busy", 32'(busy), 32'd0);
        chk("t7_post_count", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
